// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   state_t      - FSM state encoding (IDLE/ISSUE/WAIT/DONE)
//   TIMEOUT_FILL - read data returned to the core when main memory never answers
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_timeout_counter.sv
// -----------------------------------------------------------------------------
// dmem_timeout_counter
// Counts enabled cycles since the last clear and raises terminal on the
// TIMEOUT_CYCLES-th enabled cycle (combinationally, in that same cycle).
// Ports:
//   clk      - clock
//   reset    - asynchronous active-low reset
//   clr      - synchronous clear (takes priority over en)
//   en       - count this cycle
//   terminal - this enabled cycle is number TIMEOUT_CYCLES since clear
// -----------------------------------------------------------------------------
module dmem_timeout_counter
   import dmem_responder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic terminal
);

   // count_reg holds the number of enabled cycles already completed, so the
   // current cycle is count_reg+1 and the range 0..TIMEOUT_CYCLES-1 suffices.
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign terminal = en && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder end of the core's data-memory port. Each core request is bridged,
// one at a time, to a ready/valid main-memory interface; the core is stalled
// while the request is outstanding. A watchdog abandons a request whose
// response never arrives and raises a sticky timeout_err.
//
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   dcache_addr     - core word address (bits [1:0] ignored)
//   dcache_re       - core read request
//   dcache_we       - core byte write enables (nonzero = write, wins over read)
//   dcache_din      - core write data
//   dcache_dout     - registered read data (holds last read result)
//   stall           - core must hold its request and freeze
//   mem_req_valid   - request valid to main memory
//   mem_req_ready   - main memory accepts the request
//   mem_req_addr    - word-aligned request address
//   mem_req_wmask   - byte mask, 0 = read
//   mem_req_wdata   - write data
//   mem_resp_valid  - one-cycle response / write acknowledge
//   mem_resp_data   - read data with mem_resp_valid
//   timeout_err     - sticky watchdog error, cleared only by reset
//
// Build option DMEM_RESPONDER_POSTED_WRITE_EN: writes accepted in IDLE are
// posted (no stall) and drain in the background; any request arriving while
// the posted write drains stalls until it completes.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           dcache_addr,
   input  logic                  dcache_re,
   input  logic [3:0]            dcache_we,
   input  logic [31:0]           dcache_din,
   output logic [31:0]           dcache_dout,
   output logic                  stall,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic [3:0]            mem_req_wmask,
   output logic [31:0]           mem_req_wdata,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_resp_data,
   output logic                  timeout_err
);

   state_t                state_reg;
   logic                  valid_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [3:0]            wmask_reg;
   logic [31:0]           wdata_reg;
   logic [31:0]           dout_reg;
   logic                  err_reg;
   logic                  stall_c;
   logic                  cnt_term;

   logic        req;
   logic [31:0] addr_aligned;

   assign req          = dcache_re | (|dcache_we);
   assign addr_aligned = dcache_addr & 32'hFFFF_FFFC;

`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
   logic is_wr;
   logic posted_reg;     // transaction in flight is a posted write
   assign is_wr = |dcache_we;
`endif

   // The watchdog only runs in WAIT and restarts from zero on every entry.
   dmem_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr      (state_reg != ST_WAIT),
      .en       (state_reg == ST_WAIT),
      .terminal (cnt_term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         valid_reg  <= 1'b0;
         addr_reg   <= '0;
         wmask_reg  <= '0;
         wdata_reg  <= '0;
         dout_reg   <= '0;
         err_reg    <= 1'b0;
`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
         posted_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req) begin
                  addr_reg  <= ADDR_WIDTH'(addr_aligned);
                  wmask_reg <= dcache_we;
                  wdata_reg <= dcache_din;
                  valid_reg <= 1'b1;
                  state_reg <= ST_ISSUE;
`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
                  posted_reg <= is_wr;
`endif
               end
            end
            ST_ISSUE: begin
               if (mem_req_ready) begin
                  valid_reg <= 1'b0;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A response in the timeout cycle still counts as a success.
               if (mem_resp_valid) begin
                  if (wmask_reg == 4'd0) dout_reg <= mem_resp_data;
                  state_reg <= ST_DONE;
               end else if (cnt_term) begin
                  err_reg <= 1'b1;
                  if (wmask_reg == 4'd0) dout_reg <= TIMEOUT_FILL;
                  state_reg <= ST_DONE;
               end
            end
            default: begin
               // DONE: core inputs are ignored so the held request is not
               // issued a second time.
               state_reg <= ST_IDLE;
`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
               posted_reg <= 1'b0;
`endif
            end
         endcase
      end
   end

   always_comb begin
      stall_c = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            stall_c = req;
`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
            if (is_wr) stall_c = 1'b0;
`endif
         end
         ST_ISSUE, ST_WAIT: begin
`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
            stall_c = posted_reg ? req : 1'b1;
`else
            stall_c = 1'b1;
`endif
         end
         default: begin
`ifdef DMEM_RESPONDER_POSTED_WRITE_EN
            // After a posted write the core's new request must keep waiting.
            stall_c = posted_reg ? req : 1'b0;
`else
            stall_c = 1'b0;
`endif
         end
      endcase
   end

   // stall is a combinational function of the core request in IDLE, so it is
   // masked while reset is asserted to keep every output at zero.
   assign stall         = stall_c & reset;
   assign mem_req_valid = valid_reg;
   assign mem_req_addr  = addr_reg;
   assign mem_req_wmask = wmask_reg;
   assign mem_req_wdata = wdata_reg;
   assign dcache_dout   = dout_reg;
   assign timeout_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dcache_addr = '0;
   logic        dcache_re = 1'b0;
   logic [3:0]  dcache_we = '0;
   logic [31:0] dcache_din = '0;
   logic [31:0] dcache_dout;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic [3:0]  mem_req_wmask;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        timeout_err;

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
      .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wmask(mem_req_wmask),
      .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .timeout_err(timeout_err)
   );

   // ---------------- main-memory model (environment) ----------------
   logic [31:0] mem_array [2048];
   bit          mem_init_done = 0;
   int          rdly_cfg = 0;      // ISSUE cycles before ready
   int          sdly_cfg = 1;      // response arrives on WAIT cycle sdly_cfg
   bit          noresp_cfg = 0;
   bit          force_resp = 0;
   int          issue_cnt = 0;
   int          wait_k = 0;
   bit          pend = 0;
   logic [10:0] pend_idx = '0;
   bit          pend_rd = 0;
   int          hs_count = 0;
   logic [31:0] hs_addr = '0;
   logic [3:0]  hs_mask = '0;
   logic [31:0] hs_wdata = '0;
   bit          first_valid = 1;
   int          unstable = 0;
   logic [31:0] v_addr = '0, v_wdata = '0;
   logic [3:0]  v_mask = '0;

   always @(negedge clk) begin
      if (!reset) begin
         if (!mem_init_done) begin
            for (int i = 0; i < 2048; i++) mem_array[i] = 32'(i) * 32'h9E37_79B1;
            mem_array[11'h400] = 32'hCAFEF00D;
            mem_init_done = 1;
         end
         issue_cnt = 0; pend = 0; first_valid = 1;
         mem_req_ready = 1'b0;
         mem_resp_valid = force_resp;
      end else begin
         mem_req_ready = 1'b0;
         mem_resp_valid = force_resp;
         if (pend) begin
            wait_k++;
            if (wait_k == sdly_cfg) begin
               mem_resp_valid = 1'b1;
               mem_resp_data = pend_rd ? mem_array[pend_idx] : $urandom;
               pend = 0;
            end
         end
         if (mem_req_valid) begin
            if (first_valid) begin
               v_addr = mem_req_addr; v_mask = mem_req_wmask; v_wdata = mem_req_wdata;
               first_valid = 0;
            end else if (mem_req_addr !== v_addr || mem_req_wmask !== v_mask ||
                         mem_req_wdata !== v_wdata) begin
               unstable++;
            end
            if (issue_cnt == rdly_cfg) begin
               mem_req_ready = 1'b1;
               hs_count++;
               hs_addr = mem_req_addr; hs_mask = mem_req_wmask; hs_wdata = mem_req_wdata;
               issue_cnt = 0; first_valid = 1;
               for (int b = 0; b < 4; b++)
                  if (mem_req_wmask[b]) mem_array[mem_req_addr[12:2]][8*b +: 8] = mem_req_wdata[8*b +: 8];
               pend = !noresp_cfg; wait_k = 0;
               pend_idx = mem_req_addr[12:2];
               pend_rd = (mem_req_wmask == 4'd0);
            end else begin
               issue_cnt++;
            end
         end
      end
   end

   // ---------------- reference model and checking ----------------
   logic [31:0] ref_mem [2048];
   logic [31:0] ref_dout = '0;
   logic        ref_err = 1'b0;
   int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One core transaction; the request is held through DONE, like the core does.
   task automatic txn(input string name, input bit is_wr, input bit also_re,
                      input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din,
                      input int rdly, input int sdly, input bit noresp);
      int cyc, hs0, un0, exp_stall;
      bit done;
      logic [10:0] idx;
      rdly_cfg = rdly; sdly_cfg = sdly; noresp_cfg = noresp;
      hs0 = hs_count; un0 = unstable;
      @(posedge clk); #1;
      dcache_addr = addr;
      dcache_re   = is_wr ? also_re : 1'b1;
      dcache_we   = is_wr ? we : 4'd0;
      dcache_din  = din;
      cyc = 0; done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (stall) cyc++; else done = 1;
      end
      check({name, "_done"}, 32'(done), 32'd1);
      // expected results from the core-side view of the request
      idx = addr[12:2];
      if (is_wr) begin
         for (int b = 0; b < 4; b++) if (we[b]) ref_mem[idx][8*b +: 8] = din[8*b +: 8];
      end else begin
         ref_dout = noresp ? 32'hDEADBEEF : ref_mem[idx];
      end
      if (noresp) ref_err = 1'b1;
      exp_stall = 2 + rdly + (noresp ? TO : sdly);
      check({name, "_stall_cycles"}, 32'(cyc), 32'(exp_stall));
      check({name, "_dout"}, dcache_dout, ref_dout);
      check({name, "_err"}, 32'(timeout_err), 32'(ref_err));
      check({name, "_addr"}, hs_addr, {addr[31:2], 2'b00});
      check({name, "_mask"}, 32'(hs_mask), 32'(is_wr ? we : 4'd0));
      if (is_wr) check({name, "_wdata"}, hs_wdata, din);
      $display("txn %-8s wr=%0d addr=%h we=%b stall_cycles=%0d dout=%h err=%0d",
               name, is_wr, addr, is_wr ? we : 4'd0, cyc, dcache_dout, timeout_err);
      @(posedge clk); #1;
      dcache_re = 1'b0; dcache_we = 4'd0;
      repeat (3) @(negedge clk);
      check({name, "_issued_once"}, 32'(hs_count - hs0), 32'd1);
      check({name, "_stable"}, 32'(unstable - un0), 32'd0);
      check({name, "_idle_valid"}, 32'(mem_req_valid), 32'd0);
   endtask

   initial begin
      bit          w, rr;
      logic [31:0] a, d;
      logic [3:0]  e;
      int          hs_before;

      for (int i = 0; i < 2048; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;
      ref_mem[11'h400] = 32'hCAFEF00D;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_valid", 32'(mem_req_valid), 32'd0);
      check("rst_dout", dcache_dout, 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      check("rst_addr", mem_req_addr, 32'd0);
      @(posedge clk); #1 reset = 1'b1;

      // directed cases
      txn("read", 0, 0, 32'h0000_1003, 4'd0, 32'd0, 0, 1, 0);
      txn("write", 1, 0, 32'h0000_2008, 4'b0110, 32'h1122_3344, 4, 1, 0);
      txn("rdback", 0, 0, 32'h0000_2009, 4'd0, 32'd0, 1, 2, 0);
      txn("wr_re", 1, 1, 32'h0000_0404, 4'b1111, 32'hA5A5_5A5A, 0, 2, 0);
      txn("rd_wrre", 0, 0, 32'h0000_0406, 4'd0, 32'd0, 0, 1, 0);
      txn("tie", 0, 0, 32'h0000_0010, 4'd0, 32'd0, 0, TO, 0);

      // randomized traffic
      for (int t = 0; t < 16; t++) begin
         w  = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 2047) << 2) | $urandom_range(0, 3);
         e  = 4'($urandom_range(1, 15));
         d  = $urandom;
         txn("rand", w, rr, a, e, d, $urandom_range(0, 3), $urandom_range(1, 4), 0);
      end

      // watchdog
      txn("timeout", 0, 0, 32'h0000_0100, 4'd0, 32'd0, 1, 1, 1);
      txn("post_to", 0, 0, 32'h0000_1000, 4'd0, 32'd0, 0, 1, 0);

      // asynchronous reset in the middle of WAIT, then a stray response
      rdly_cfg = 0; noresp_cfg = 1;
      @(posedge clk); #1;
      dcache_addr = 32'h0000_0200; dcache_re = 1'b1;
      repeat (3) @(negedge clk);
      hs_before = hs_count;
      reset = 1'b0;
      #1;
      ref_dout = '0; ref_err = 1'b0;
      check("mid_rst_stall", 32'(stall), 32'd0);
      check("mid_rst_valid", 32'(mem_req_valid), 32'd0);
      check("mid_rst_dout", dcache_dout, ref_dout);
      check("mid_rst_err", 32'(timeout_err), 32'(ref_err));
      @(posedge clk); #1 dcache_re = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      force_resp = 1;
      @(negedge clk); #1 force_resp = 0;
      repeat (3) @(negedge clk);
      check("late_resp_stall", 32'(stall), 32'd0);
      check("late_resp_valid", 32'(mem_req_valid), 32'd0);
      check("late_resp_dout", dcache_dout, 32'd0);
      check("late_resp_hs", 32'(hs_count - hs_before), 32'd0);
      txn("after_rst", 0, 0, 32'h0000_2008, 4'd0, 32'd0, 0, 1, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // global time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL time_limit: observed timeout expected completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port: accepts the dcache_addr/dcache_re/dcache_we/dcache_din requests the core issues.
- Returns read data on dcache_dout and drives stall while a request is outstanding.
- Bridges each request to a ready/valid main-memory interface, one transaction at a time.
- Includes a response-timeout watchdog with a sticky error flag.

Parameters:
- ADDR_WIDTH, 32, width of main-memory address; the low two bits of mem_req_addr are always 0.
- TIMEOUT_CYCLES, 1024, number of WAIT cycles without mem_resp_valid before the error is flagged; minimum 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- dcache_addr  input  32  word address from core; bits [1:0] ignored
- dcache_re  input  1  read request
- dcache_we  input  4  byte write enables; nonzero = write request
- dcache_din  input  32  write data, byte lanes per dcache_we
- dcache_dout  output  32  registered read data
- stall  output  1  core must hold its request and freeze
- mem_req_valid  output  1  request valid to main memory
- mem_req_ready  input  1  main memory accepts request
- mem_req_addr  output  ADDR_WIDTH  word-aligned address
- mem_req_wmask  output  4  byte mask; 0 = read
- mem_req_wdata  output  32  write data
- mem_resp_valid  input  1  response or write acknowledge, one cycle
- mem_resp_data  input  32  read data, valid with mem_resp_valid
- timeout_err  output  1  sticky watchdog error

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0, including dcache_dout and timeout_err.
  - Timeout counter cleared.
  - An outstanding transaction is abandoned. A mem_resp_valid arriving after reset releases is ignored because state is IDLE.
- Request detect: req = dcache_re | (|dcache_we). If both read and write are present, the write wins and the read is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - stall = req (combinational, same cycle).
  - On req: latch address {addr[31:2],2'b00}, wmask (0 for reads), and wdata into request registers; go to ISSUE.
- ISSUE:
  - mem_req_valid=1, stall=1.
  - Address, mask and data held stable until mem_req_ready.
  - When mem_req_ready=1, go to WAIT.
- WAIT:
  - stall=1; the counter increments each cycle.
  - On mem_resp_valid: if the latched request is a read, dcache_dout <= mem_resp_data; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES: set timeout_err, set dcache_dout=32'hDEADBEEF for reads, go to DONE.
  - mem_resp_valid in the same cycle as the timeout: the response wins and timeout_err stays unchanged.
- DONE:
  - stall=0 for exactly one cycle; the core advances.
  - Core inputs are ignored this cycle, so the held request is not re-issued. Go to IDLE.
- Latency, zero-wait memory (ready=1, response one cycle later): IDLE→ISSUE→WAIT→DONE, so stall is high for 3 cycles.
- dcache_dout holds the last read result indefinitely; writes do not change it.
- mem_resp_valid outside WAIT is ignored.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro: DMEM_RESPONDER_POSTED_WRITE_EN.
- Defined:
  - A write in IDLE with no write pending is captured into a one-entry write buffer with stall=0 (zero-stall posted write).
  - The buffer drains through ISSUE/WAIT in the background.
  - Any request arriving while the buffer is pending stalls until the drain completes; it then proceeds normally from IDLE.
  - DONE after a posted write does not drop stall to the core.
- Undefined: every write stalls as described in Behaviour.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3) and the DEADBEEF timeout-fill constant.
- Sub-module: dmem_timeout_counter, a clear/enable counter with a terminal flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset: apply reset=0 mid-WAIT → stall=0, dcache_dout=0, mem_req_valid=0 immediately; a late mem_resp_valid is ignored.
- Read: re=1, addr=0x1003, memory returns 0xCAFEF00D one cycle after ready → mem_req_addr=0x1000, mask=0, stall high 3 cycles, dcache_dout=0xCAFEF00D in DONE.
- Write: we=4'b0110, din=0x11223344, ready delayed 4 cycles → req held stable 5 cycles, mask=0110, dcache_dout unchanged.
- Backpressure and hold: a request held through DONE is issued exactly once (count mem_req_valid&ready = 1).
- Timeout: TIMEOUT_CYCLES=8, no response → stall released after the 8th WAIT cycle, timeout_err=1, dcache_dout=0xDEADBEEF; a later read succeeds with timeout_err still 1.
- Posted write (macro on): write then immediate read → write stall=0; read stalls until the write ack, then completes normally.
